// File: rtl/road_scroll.sv
// road_scroll: per-frame road scroller; once per vertical blank it moves the road tile
// vertically, picks a new tile from an LFSR when a tile boundary is crossed, and steers road_X.
module road_scroll #(
    parameter logic [8:0] X_INIT    = 9'd144,
    parameter logic [8:0] X_MIN     = 9'd64,
    parameter logic [8:0] X_MAX     = 9'd240,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       frame_start,
    input  logic [3:0] speed,
    output logic [8:0] road_X,
    output logic [8:0] road_Y,
    output logic [8:0] sprite_number,
    output logic       mirror,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, WAIT, SCROLL, TILE, STEER} state_t;

    // An all-zero LFSR would lock up, so a zero seed is forced to 1.
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    state_t     r_state, w_next;
    logic [8:0] r_road_X, r_target_X, r_road_Y;
    logic [1:0] r_sprite;
    logic       r_mirror, r_cross, r_busy;
    logic [7:0] r_lfsr;
    logic [7:0] w_lfsr_next;
    logic [8:0] w_y_next;
    logic [9:0] w_sum;
    logic [8:0] w_target;

    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_y_next    = r_road_Y - {5'd0, speed};
    assign w_sum       = {1'b0, X_MIN} + {3'd0, w_lfsr_next[6:0]};
    assign w_target    = (w_sum > {1'b0, X_MAX}) ? X_MAX : w_sum[8:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = enable ? WAIT : IDLE;
            WAIT:    w_next = !enable ? IDLE : (frame_start ? SCROLL : WAIT);
            SCROLL:  w_next = TILE;
            TILE:    w_next = STEER;
            default: w_next = WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_road_X   <= X_INIT;
            r_target_X <= X_INIT;
            r_road_Y   <= 9'd0;
            r_sprite   <= 2'd0;
            r_mirror   <= 1'b0;
            r_lfsr     <= SEED;
            r_cross    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == SCROLL) || (w_next == TILE) || (w_next == STEER);
            case (r_state)
                SCROLL: begin
                    r_road_Y <= w_y_next;
                    r_cross  <= r_road_Y[5] ^ w_y_next[5];
                end
                TILE: if (r_cross) begin
                    r_lfsr     <= w_lfsr_next;
                    r_sprite   <= w_lfsr_next[1:0];
                    r_mirror   <= ~r_mirror;
                    r_target_X <= w_target;
                end
                STEER: r_road_X <= (r_road_X < r_target_X) ? r_road_X + 9'd1 :
                                   (r_road_X > r_target_X) ? r_road_X - 9'd1 : r_road_X;
                default: ;
            endcase
        end
    end

    assign road_X        = r_road_X;
    assign road_Y        = r_road_Y;
    assign sprite_number = {7'd0, r_sprite};
    assign mirror        = r_mirror;
    assign busy          = r_busy;
endmodule
